// File: rtl/bitunit_pkg.sv
// Shared constants for the PLC bit unit with nesting stack.
// Holds opcode encodings, logic-unit function codes, operand source selects
// and the nesting-stack entry layout.
package bitunit_pkg;

  // Bit-unit opcodes (12..15 decode as NOP)
  localparam logic [3:0] OP_NOP        = 4'd0;
  localparam logic [3:0] OP_LOAD       = 4'd1;
  localparam logic [3:0] OP_LOGIC      = 4'd2;
  localparam logic [3:0] OP_NOT        = 4'd3;
  localparam logic [3:0] OP_SET        = 4'd4;
  localparam logic [3:0] OP_CLR        = 4'd5;
  localparam logic [3:0] OP_NEST_OPEN  = 4'd6;
  localparam logic [3:0] OP_NEST_CLOSE = 4'd7;
  localparam logic [3:0] OP_EDGE_POS   = 4'd8;
  localparam logic [3:0] OP_EDGE_NEG   = 4'd9;
  localparam logic [3:0] OP_NEST_FLUSH = 4'd10;
  localparam logic [3:0] OP_CLR_ERR    = 4'd11;

  // Logic-unit functions
  localparam logic [1:0] LU_AND  = 2'd0;
  localparam logic [1:0] LU_OR   = 2'd1;
  localparam logic [1:0] LU_XOR  = 2'd2;
  localparam logic [1:0] LU_ANDN = 2'd3;

  // Operand source selects (6/7 give constant 0)
  localparam logic [2:0] SRC_ARG = 3'd0;
  localparam logic [2:0] SRC_RAM = 3'd1;
  localparam logic [2:0] SRC_REG = 3'd2;
  localparam logic [2:0] SRC_SEM = 3'd3;
  localparam logic [2:0] SRC_OV  = 3'd4;
  localparam logic [2:0] SRC_CMP = 3'd5;

  // Nesting-stack entry: saved RLO plus the function to apply on close
  localparam int unsigned NEST_W = 3;

  typedef struct packed {
    logic       rlo;
    logic [1:0] op;
  } nest_entry_t;

endpackage

// File: rtl/bit_lu.sv
// Combinational 1-bit logic unit.
// Ports:
//   op - function select (AND, OR, XOR, ANDN = a & ~b)
//   a  - first operand
//   b  - second operand
//   y  - result
module bit_lu
  import bitunit_pkg::*;
(
  input  logic [1:0] op,
  input  logic       a,
  input  logic       b,
  output logic       y
);

  always_comb begin
    y = 1'b0;
    case (op)
      LU_AND:  y = a & b;
      LU_OR:   y = a | b;
      LU_XOR:  y = a ^ b;
      LU_ANDN: y = a & ~b;
      default: y = 1'b0;
    endcase
  end

endmodule

// File: rtl/bit_unit_nest.sv
// PLC bit unit: RLO accumulator, 4-function logic unit and a LIFO nesting
// stack for bracketed expressions with sticky overflow/underflow flags.
// Optional per-slot edge memory for FP/FN is enabled by defining
// BITUNIT_EDGE_EN; without it opcodes 8/9 are NOPs and BU_EdgeIdx is ignored.
// Ports:
//   CLK, CPU_Reset       - clock, asynchronous active-high reset
//   BU_Valid, BU_OPCode  - execute opcode this cycle
//   BU_LU_OPCode         - logic function for LOGIC / pushed with NEST_OPEN
//   BU_SrcSel            - operand B select over the six 1-bit sources
//   BU_EdgeIdx           - edge-memory slot
//   BU_RLO, BU_NestLevel - registered RLO and stack occupancy
//   BU_NestOvf/Unf       - sticky push-on-full / pop-on-empty errors
module bit_unit_nest
  import bitunit_pkg::*;
#(
  parameter int unsigned NEST_DEPTH = 7,
  parameter int unsigned EDGE_SLOTS = 8,
  parameter int unsigned EDGE_IW    = $clog2(EDGE_SLOTS)
) (
  input  logic               CLK,
  input  logic               CPU_Reset,
  input  logic               BU_Valid,
  input  logic [3:0]         BU_OPCode,
  input  logic [1:0]         BU_LU_OPCode,
  input  logic [2:0]         BU_SrcSel,
  input  logic               BU_ArgToSet,
  input  logic               BU_RAMData,
  input  logic               BU_Registers,
  input  logic               BU_Semaphore,
  input  logic               BU_OVResoult,
  input  logic               BU_ComparatorResoult,
  input  logic [EDGE_IW-1:0] BU_EdgeIdx,
  output logic               BU_RLO,
  output logic [4:0]         BU_NestLevel,
  output logic               BU_NestOvf,
  output logic               BU_NestUnf
);

  localparam int unsigned IDX_W = (NEST_DEPTH > 1) ? $clog2(NEST_DEPTH) : 1;

  logic        rlo_q, rlo_d;
  logic [4:0]  level_q, level_d;
  logic        ovf_q, ovf_d;
  logic        unf_q, unf_d;
  logic        push_en;
  nest_entry_t stack_q [NEST_DEPTH];
  nest_entry_t stack_top;
  logic [IDX_W-1:0] push_idx;
  logic [IDX_W-1:0] top_idx;
  logic        operand_b;
  logic        lu_logic_y;
  logic        lu_close_y;
  logic        nest_full;
  logic        nest_empty;

  always_comb begin
    operand_b = 1'b0;
    case (BU_SrcSel)
      SRC_ARG: operand_b = BU_ArgToSet;
      SRC_RAM: operand_b = BU_RAMData;
      SRC_REG: operand_b = BU_Registers;
      SRC_SEM: operand_b = BU_Semaphore;
      SRC_OV:  operand_b = BU_OVResoult;
      SRC_CMP: operand_b = BU_ComparatorResoult;
      default: operand_b = 1'b0;
    endcase
  end

  // level is never above NEST_DEPTH, so truncation to IDX_W is lossless when
  // it is used; top_idx is only meaningful when the stack is non-empty.
  assign push_idx   = IDX_W'(level_q);
  assign top_idx    = IDX_W'(level_q - 5'd1);
  assign stack_top  = stack_q[top_idx];
  assign nest_full  = (level_q == 5'(NEST_DEPTH));
  assign nest_empty = (level_q == 5'd0);

  bit_lu u_lu_logic (
    .op (BU_LU_OPCode),
    .a  (rlo_q),
    .b  (operand_b),
    .y  (lu_logic_y)
  );

  // Closing a bracket combines the saved outer RLO with the inner result
  bit_lu u_lu_close (
    .op (stack_top.op),
    .a  (stack_top.rlo),
    .b  (rlo_q),
    .y  (lu_close_y)
  );

`ifdef BITUNIT_EDGE_EN
  logic [EDGE_SLOTS-1:0] edge_q, edge_d;
  logic                  edge_m;

  assign edge_m = edge_q[BU_EdgeIdx];

  always_ff @(posedge CLK or posedge CPU_Reset) begin
    if (CPU_Reset) begin
      edge_q <= '0;
    end else begin
      edge_q <= edge_d;
    end
  end
`else
  logic unused_edge_idx;
  assign unused_edge_idx = ^BU_EdgeIdx;
`endif

  always_comb begin
    rlo_d   = rlo_q;
    level_d = level_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    push_en = 1'b0;
`ifdef BITUNIT_EDGE_EN
    edge_d  = edge_q;
`endif
    if (BU_Valid) begin
      case (BU_OPCode)
        OP_LOAD:  rlo_d = operand_b;
        OP_LOGIC: rlo_d = lu_logic_y;
        OP_NOT:   rlo_d = ~rlo_q;
        OP_SET:   rlo_d = 1'b1;
        OP_CLR:   rlo_d = 1'b0;
        OP_NEST_OPEN: begin
          if (nest_full) begin
            ovf_d = 1'b1;
          end else begin
            push_en = 1'b1;
            rlo_d   = operand_b;
            level_d = level_q + 5'd1;
          end
        end
        OP_NEST_CLOSE: begin
          if (nest_empty) begin
            unf_d = 1'b1;
          end else begin
            rlo_d   = lu_close_y;
            level_d = level_q - 5'd1;
          end
        end
`ifdef BITUNIT_EDGE_EN
        OP_EDGE_POS: begin
          rlo_d              = rlo_q & ~edge_m;
          edge_d[BU_EdgeIdx] = rlo_q;
        end
        OP_EDGE_NEG: begin
          rlo_d              = ~rlo_q & edge_m;
          edge_d[BU_EdgeIdx] = rlo_q;
        end
`endif
        OP_NEST_FLUSH: level_d = 5'd0;
        OP_CLR_ERR: begin
          ovf_d = 1'b0;
          unf_d = 1'b0;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge CPU_Reset) begin
    if (CPU_Reset) begin
      rlo_q   <= 1'b0;
      level_q <= 5'd0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      rlo_q   <= rlo_d;
      level_q <= level_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  always_ff @(posedge CLK or posedge CPU_Reset) begin
    if (CPU_Reset) begin
      for (int i = 0; i < int'(NEST_DEPTH); i++) begin
        stack_q[i] <= '0;
      end
    end else if (push_en) begin
      stack_q[push_idx] <= '{rlo: rlo_q, op: BU_LU_OPCode};
    end
  end

  assign BU_RLO       = rlo_q;
  assign BU_NestLevel = level_q;
  assign BU_NestOvf   = ovf_q;
  assign BU_NestUnf   = unf_q;

endmodule

// File: tb/tb_bit_unit_nest.sv
// Directed self-checking bench for bit_unit_nest (NEST_DEPTH=7, EDGE_SLOTS=8).
// The edge-memory steps follow BITUNIT_EDGE_EN the same way the design does.
module tb_bit_unit_nest;
  import bitunit_pkg::*;

  logic       CLK = 1'b0;
  logic       CPU_Reset;
  logic       BU_Valid;
  logic [3:0] BU_OPCode;
  logic [1:0] BU_LU_OPCode;
  logic [2:0] BU_SrcSel;
  logic       BU_ArgToSet, BU_RAMData, BU_Registers;
  logic       BU_Semaphore, BU_OVResoult, BU_ComparatorResoult;
  logic [2:0] BU_EdgeIdx;
  logic       BU_RLO;
  logic [4:0] BU_NestLevel;
  logic       BU_NestOvf, BU_NestUnf;

  int n_checks = 0;
  int n_errors = 0;

  bit_unit_nest #(
    .NEST_DEPTH (7),
    .EDGE_SLOTS (8),
    .EDGE_IW    (3)
  ) dut (
    .CLK                  (CLK),
    .CPU_Reset            (CPU_Reset),
    .BU_Valid             (BU_Valid),
    .BU_OPCode            (BU_OPCode),
    .BU_LU_OPCode         (BU_LU_OPCode),
    .BU_SrcSel            (BU_SrcSel),
    .BU_ArgToSet          (BU_ArgToSet),
    .BU_RAMData           (BU_RAMData),
    .BU_Registers         (BU_Registers),
    .BU_Semaphore         (BU_Semaphore),
    .BU_OVResoult         (BU_OVResoult),
    .BU_ComparatorResoult (BU_ComparatorResoult),
    .BU_EdgeIdx           (BU_EdgeIdx),
    .BU_RLO               (BU_RLO),
    .BU_NestLevel         (BU_NestLevel),
    .BU_NestOvf           (BU_NestOvf),
    .BU_NestUnf           (BU_NestUnf)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issue one operation; returns 1 time unit after the executing edge
  task automatic do_op(input logic [3:0] op, input logic [1:0] lu, input logic [2:0] src);
    BU_Valid     = 1'b1;
    BU_OPCode    = op;
    BU_LU_OPCode = lu;
    BU_SrcSel    = src;
    @(posedge CLK);
    #1;
    BU_Valid  = 1'b0;
    BU_OPCode = OP_NOP;
  endtask

  initial begin
    CPU_Reset = 1'b1;
    BU_Valid = 1'b0; BU_OPCode = OP_NOP; BU_LU_OPCode = LU_AND; BU_SrcSel = SRC_ARG;
    BU_ArgToSet = 1'b0; BU_RAMData = 1'b0; BU_Registers = 1'b0;
    BU_Semaphore = 1'b0; BU_OVResoult = 1'b0; BU_ComparatorResoult = 1'b0;
    BU_EdgeIdx = 3'd0;
    #1;
    check("reset_rlo", 8'(BU_RLO), 8'd0);
    check("reset_level", 8'(BU_NestLevel), 8'd0);
    check("reset_ovf", 8'(BU_NestOvf), 8'd0);
    check("reset_unf", 8'(BU_NestUnf), 8'd0);
    @(posedge CLK);
    #1;
    CPU_Reset = 1'b0;

    // LOAD then AND
    BU_ArgToSet = 1'b1;
    do_op(OP_LOAD, LU_AND, SRC_ARG);
    check("load_arg", 8'(BU_RLO), 8'd1);
    BU_RAMData = 1'b0;
    do_op(OP_LOGIC, LU_AND, SRC_RAM);
    check("and_ram", 8'(BU_RLO), 8'd0);

    // Valid low: SET must not execute
    BU_OPCode = OP_SET;
    @(posedge CLK);
    #1;
    BU_OPCode = OP_NOP;
    check("valid_low_hold", 8'(BU_RLO), 8'd0);

    // A(x O y), RLO=1, x=0 (arg), y=1 (registers)
    do_op(OP_SET, LU_AND, SRC_ARG);
    check("set", 8'(BU_RLO), 8'd1);
    BU_ArgToSet = 1'b0; BU_Registers = 1'b1;
    do_op(OP_NEST_OPEN, LU_AND, SRC_ARG);
    check("expr_open_rlo", 8'(BU_RLO), 8'd0);
    check("expr_open_lvl", 8'(BU_NestLevel), 8'd1);
    do_op(OP_LOGIC, LU_OR, SRC_REG);
    check("expr_or_rlo", 8'(BU_RLO), 8'd1);
    check("expr_or_lvl", 8'(BU_NestLevel), 8'd1);
    do_op(OP_NEST_CLOSE, LU_AND, SRC_ARG);
    check("expr_close_rlo", 8'(BU_RLO), 8'd1);
    check("expr_close_lvl", 8'(BU_NestLevel), 8'd0);

    // 1 ANDN (semaphore=1): push {1,ANDN}, RLO=1; close -> 1 & ~1 = 0
    BU_Semaphore = 1'b1;
    do_op(OP_NEST_OPEN, LU_ANDN, SRC_SEM);
    check("andn_open_rlo", 8'(BU_RLO), 8'd1);
    do_op(OP_NEST_CLOSE, LU_AND, SRC_ARG);
    check("andn_close_rlo", 8'(BU_RLO), 8'd0);

    // XOR with OV=1, NOT, comparator load, constant-0 source, opcode 12, flush
    BU_OVResoult = 1'b1;
    do_op(OP_LOGIC, LU_XOR, SRC_OV);
    check("xor_ov", 8'(BU_RLO), 8'd1);
    do_op(OP_NOT, LU_AND, SRC_ARG);
    check("not", 8'(BU_RLO), 8'd0);
    BU_ComparatorResoult = 1'b1;
    do_op(OP_LOAD, LU_AND, SRC_CMP);
    check("load_cmp", 8'(BU_RLO), 8'd1);
    do_op(4'd12, LU_AND, SRC_ARG);
    check("op12_nop", 8'(BU_RLO), 8'd1);
    do_op(OP_CLR, LU_AND, SRC_ARG);
    check("clr", 8'(BU_RLO), 8'd0);
    do_op(OP_LOAD, LU_AND, 3'd6);
    check("load_const0", 8'(BU_RLO), 8'd0);

    // Overflow: RLO=0 pushed first, then six {1,AND}; 8th open has B=0
    BU_ArgToSet = 1'b1;
    for (int i = 1; i <= 7; i++) begin
      do_op(OP_NEST_OPEN, LU_AND, SRC_ARG);
      check($sformatf("ovf_lvl_%0d", i), 8'(BU_NestLevel), 8'(i));
    end
    check("ovf_not_yet", 8'(BU_NestOvf), 8'd0);
    BU_ArgToSet = 1'b0;
    do_op(OP_NEST_OPEN, LU_AND, SRC_ARG);
    check("ovf_lvl_8", 8'(BU_NestLevel), 8'd7);
    check("ovf_flag", 8'(BU_NestOvf), 8'd1);
    check("ovf_rlo_kept", 8'(BU_RLO), 8'd1);
    do_op(OP_CLR_ERR, LU_AND, SRC_ARG);
    check("ovf_cleared", 8'(BU_NestOvf), 8'd0);

    // Underflow: six closes AND(1,1)=1, 7th AND(0,1)=0, 8th underflows
    for (int i = 1; i <= 7; i++) begin
      do_op(OP_NEST_CLOSE, LU_AND, SRC_ARG);
      check($sformatf("unf_lvl_%0d", i), 8'(BU_NestLevel), 8'(7 - i));
    end
    check("unf_rlo_7", 8'(BU_RLO), 8'd0);
    check("unf_not_yet", 8'(BU_NestUnf), 8'd0);
    do_op(OP_NEST_CLOSE, LU_AND, SRC_ARG);
    check("unf_lvl_8", 8'(BU_NestLevel), 8'd0);
    check("unf_flag", 8'(BU_NestUnf), 8'd1);
    check("unf_rlo_kept", 8'(BU_RLO), 8'd0);

    // Flush keeps flags and RLO
    BU_ArgToSet = 1'b1;
    do_op(OP_NEST_OPEN, LU_AND, SRC_ARG);
    do_op(OP_NEST_FLUSH, LU_AND, SRC_ARG);
    check("flush_lvl", 8'(BU_NestLevel), 8'd0);
    check("flush_rlo", 8'(BU_RLO), 8'd1);
    check("flush_keeps_unf", 8'(BU_NestUnf), 8'd1);
    do_op(OP_CLR_ERR, LU_AND, SRC_ARG);
    check("unf_cleared", 8'(BU_NestUnf), 8'd0);

    // Asynchronous reset mid-sequence at level 3, RLO=1, with Unf set
    do_op(OP_NEST_CLOSE, LU_AND, SRC_ARG);
    for (int i = 0; i < 3; i++) do_op(OP_NEST_OPEN, LU_AND, SRC_ARG);
    check("pre_rst_lvl", 8'(BU_NestLevel), 8'd3);
    check("pre_rst_rlo", 8'(BU_RLO), 8'd1);
    check("pre_rst_unf", 8'(BU_NestUnf), 8'd1);
    BU_Valid = 1'b1; BU_OPCode = OP_NEST_OPEN;
    #2;
    CPU_Reset = 1'b1;
    #1;
    check("arst_rlo", 8'(BU_RLO), 8'd0);
    check("arst_lvl", 8'(BU_NestLevel), 8'd0);
    check("arst_ovf", 8'(BU_NestOvf), 8'd0);
    check("arst_unf", 8'(BU_NestUnf), 8'd0);
    BU_Valid = 1'b0; BU_OPCode = OP_NOP;
    #2;
    CPU_Reset = 1'b0;
    @(posedge CLK);
    #1;

`ifdef BITUNIT_EDGE_EN
    begin
      logic [3:0] seq;
      logic [3:0] exp_pos;
      logic [3:0] exp_neg;
      seq = 4'b0110; exp_pos = 4'b0010; exp_neg = 4'b1000;  // bit i = step i
      BU_EdgeIdx = 3'd2;
      for (int i = 0; i < 4; i++) begin
        BU_ArgToSet = seq[i];
        do_op(OP_LOAD, LU_AND, SRC_ARG);
        do_op(OP_EDGE_POS, LU_AND, SRC_ARG);
        check($sformatf("edge_pos_%0d", i), 8'(BU_RLO), 8'(exp_pos[i]));
      end
      for (int i = 0; i < 4; i++) begin
        BU_ArgToSet = seq[i];
        do_op(OP_LOAD, LU_AND, SRC_ARG);
        do_op(OP_EDGE_NEG, LU_AND, SRC_ARG);
        check($sformatf("edge_neg_%0d", i), 8'(BU_RLO), 8'(exp_neg[i]));
      end
      // Slot 3 never written: rising edge seen on first use
      BU_EdgeIdx = 3'd3; BU_ArgToSet = 1'b1;
      do_op(OP_LOAD, LU_AND, SRC_ARG);
      do_op(OP_EDGE_POS, LU_AND, SRC_ARG);
      check("edge_slot3", 8'(BU_RLO), 8'd1);
    end
`else
    BU_ArgToSet = 1'b1; BU_EdgeIdx = 3'd2;
    do_op(OP_LOAD, LU_AND, SRC_ARG);
    do_op(OP_EDGE_POS, LU_AND, SRC_ARG);
    check("noedge_pos_rlo", 8'(BU_RLO), 8'd1);
    check("noedge_pos_lvl", 8'(BU_NestLevel), 8'd0);
    do_op(OP_EDGE_NEG, LU_AND, SRC_ARG);
    check("noedge_neg_rlo", 8'(BU_RLO), 8'd1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/bit_unit_nest.md
Name: bit_unit_nest

Overview:
- Parametrised successor of the PLC bit unit.
- Holds the RLO (result of logic operation) accumulator and combines it with a selected 1-bit operand through a 4-function logic unit.
- Adds a nesting stack for bracketed expressions "A(", "O(", ")" of configurable depth, with overflow/underflow detection.
- Optionally adds per-slot edge-detection memory (FP/FN).
- Sits between the instruction decoder and the word unit / RAM in each PLC core.

Parameters:
- NEST_DEPTH, 7, number of nesting-stack entries (1..16).
- EDGE_SLOTS, 8, number of edge-memory bits (power of 2, >=2; used only with the optional feature).
- EDGE_IW, $clog2(EDGE_SLOTS), width of the edge index.

Ports:
- CLK  in  1  core clock, rising edge.
- CPU_Reset  in  1  asynchronous, active-high reset.
- BU_Valid  in  1  execute BU_OPCode this cycle.
- BU_OPCode  in  4  operation (see Behaviour).
- BU_LU_OPCode  in  2  logic function: 00 AND, 01 OR, 10 XOR, 11 ANDN (A & ~B).
- BU_SrcSel  in  3  operand select: 0 ArgToSet, 1 RAMData, 2 Registers, 3 Semaphore, 4 OVResoult, 5 ComparatorResoult, 6/7 constant 0.
- BU_ArgToSet, BU_RAMData, BU_Registers, BU_Semaphore, BU_OVResoult, BU_ComparatorResoult  in  1 each  operand sources.
- BU_EdgeIdx  in  EDGE_IW  edge-memory slot.
- BU_RLO  out  1  registered RLO.
- BU_NestLevel  out  5  current stack occupancy.
- BU_NestOvf  out  1  sticky push-on-full error.
- BU_NestUnf  out  1  sticky pop-on-empty error.

Behaviour:
- Reset: all outputs are 0, the stack is emptied and edge memory is cleared. Reset is asynchronous and takes effect immediately, including mid-sequence; it aborts any pending operation.
- Operations execute only when BU_Valid=1, on the rising edge of CLK.
- Results are visible on the outputs one cycle after issue. Back-to-back issue is allowed every cycle. There is no stall and no handshake back to the decoder.
- When BU_Valid=0 all state holds.
- Operand B is the combinational source selected by BU_SrcSel.
- Opcodes:
  - 0 NOP: no state change.
  - 1 LOAD: RLO<=B.
  - 2 LOGIC: RLO<=LU(RLO,B) using BU_LU_OPCode.
  - 3 NOT: RLO<=~RLO.
  - 4 SET: RLO<=1.
  - 5 CLR: RLO<=0.
  - 6 NEST_OPEN: push {RLO, BU_LU_OPCode}; RLO<=B; level+1.
  - 7 NEST_CLOSE: pop {r, op}; RLO<=LU_op(r, RLO); level-1.
  - 8 EDGE_POS, 9 EDGE_NEG: see Optional Feature.
  - 10 NEST_FLUSH: level<=0; RLO unchanged.
  - 11 CLR_ERR: BU_NestOvf<=0, BU_NestUnf<=0.
  - 12-15: treated as NOP.
- Stack:
  - LIFO; entry at index level-1 is the top.
  - NEST_OPEN at level==NEST_DEPTH: no push, RLO and level unchanged, BU_NestOvf<=1.
  - NEST_CLOSE at level==0: no pop, RLO unchanged, BU_NestUnf<=1.
  - Error flags stay set until CLR_ERR or reset. Operations continue normally while a flag is set.
  - NEST_FLUSH does not clear the error flags.
- BU_NestLevel is zero-extended to 5 bits.

Optional Feature:
- Macro: BITUNIT_EDGE_EN.
- Defined: EDGE_SLOTS-bit edge memory M, indexed by BU_EdgeIdx.
  - EDGE_POS: RLO<=RLO & ~M[i]; M[i]<=RLO.
  - EDGE_NEG: RLO<=~RLO & M[i]; M[i]<=RLO.
  - Both use the pre-update values of RLO and M[i].
  - Other slots are unchanged.
- Undefined: no edge memory is instantiated. Opcodes 8/9 act as NOP, and BU_EdgeIdx is ignored.

Decomposition:
- Package bitunit_pkg holds:
  - opcode localparams (OP_NOP..OP_CLR_ERR);
  - LU codes LU_AND/LU_OR/LU_XOR/LU_ANDN;
  - source-select codes SRC_ARG..SRC_CMP;
  - the nest-entry width constant (3).
- One combinational sub-module, bit_lu (2-bit opcode, two 1-bit inputs, 1-bit result). It is instantiated twice: once for LOGIC and once for NEST_CLOSE.

Test Plan:
- Reset, then LOAD SrcSel=0 with ArgToSet=1, then LOGIC AND with RAMData=0 -> BU_RLO 1 then 0, one cycle after each issue.
- Expression A(x O y), with RLO=1, x=0, y=1: NEST_OPEN LU=AND src x, LOGIC OR src y, NEST_CLOSE -> RLO 0, then 1, then 1; BU_NestLevel 1, 1, 0.
- NEST_DEPTH=7: eight NEST_OPENs -> level stays 7 and BU_NestOvf=1 after the 8th. CLR_ERR -> 0. Eight NEST_CLOSEs -> level 0 and BU_NestUnf=1 after the 8th.
- Assert CPU_Reset asynchronously mid-sequence at level 3 with RLO=1 -> all outputs 0 before the next clock edge.
- With BITUNIT_EDGE_EN, slot 2: RLO sequence 0,1,1,0 with EDGE_POS each cycle (RLO reloaded before each) -> results 0,1,0,0. EDGE_NEG on the same sequence -> 0,0,0,1. Slot 3 stays unaffected.
- Without BITUNIT_EDGE_EN: EDGE_POS with RLO=1 -> RLO stays 1 and level is unchanged.
